trace_buffer_fifo: RTL

- Elastic buffer directly downstream of the trace backpressure stage.
- Accepts the tagged trace word stream (MSB=0 sample word, MSB=1 drop-marker word), drives the upstream ready, and presents words first-word-fall-through to the trace sink.
- Keeps drop statistics for software: marker count, total lost samples, and buffer high-water mark.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_buffer_fifo_if.sv | 25 ++
 rtl/trace_fifo_mem.sv | 53 +++++
 rtl/trace_buffer_fifo.sv | 98 +++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace buffer: tagged word layout and a
// saturating adder used by the drop statistics.
package trace_pkg;

  localparam int sample_width_lp = 16;
  localparam int marker_bit_lp   = sample_width_lp;
  localparam int sat_width_lp    = 64;

  typedef struct packed {
    logic                       is_marker;
    logic [sample_width_lp-1:0] payload;
  } trace_word_t;

  typedef logic [sat_width_lp-1:0] sat_t;

  // Callers zero-extend into sat_t and truncate the result back to their width.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t max_val);
    sat_t sum;
    sum = a + b;
    if ((sum < a) || (sum > max_val)) begin
      return max_val;
    end
    return sum;
  endfunction

endpackage

// File: rtl/trace_buffer_fifo_if.sv
// Trace word handshakes around the buffer: upstream push side and sink pop side.
interface trace_buffer_fifo_if
  import trace_pkg::*;
#(
  parameter int width_p = sample_width_lp + 1
);
  // Both sides transfer on a clock edge where valid and ready are both high;
  // valid must not wait on ready, and data is held while valid is high and ready is low.
  logic [width_p-1:0] fifo_data_i;
  logic               fifo_valid_i;
  logic               fifo_ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               ready_i;

  modport master (
    output fifo_data_i, fifo_valid_i, ready_i,
    input  fifo_ready_o, data_o, v_o
  );

  modport slave (
    input  fifo_data_i, fifo_valid_i, ready_i,
    output fifo_ready_o, data_o, v_o
  );
endinterface

// File: rtl/trace_fifo_mem.sv
// Word storage for the trace buffer: array, wrapping pointers and occupancy.
// The caller guarantees no push when full and no pop when empty.
module trace_fifo_mem #(
  parameter  int width_p  = 17,
  parameter  int els_p    = 8,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [width_p-1:0]  wdata_i,
  output logic [width_p-1:0]  rdata_o,
  output logic [cnt_w_lp-1:0] count_o,
  output logic [cnt_w_lp-1:0] count_next_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  // Depth is a power of two, so pointers wrap on plain overflow.
  always_comb begin
    wptr_d  = wptr_q + ptr_w_lp'(push_i);
    rptr_d  = rptr_q + ptr_w_lp'(pop_i);
    count_d = count_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o      = mem_q[rptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/trace_buffer_fifo.sv
// Elastic first-word-fall-through buffer for the tagged trace stream, with
// saturating drop statistics and an occupancy high-water mark.
module trace_buffer_fifo
  import trace_pkg::*;
#(
  parameter  int sample_width_p  = sample_width_lp,
  parameter  int counter_width_p = 16,
  parameter  int els_p           = 8,
  parameter  int stat_width_p    = 32,
  localparam int cnt_w_lp        = $clog2(els_p + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  trace_buffer_fifo_if.slave      bus,
  input  logic                    clear_stats_i,
  output logic [cnt_w_lp-1:0]     count_o,
  output logic [cnt_w_lp-1:0]     hwm_o,
  output logic [stat_width_p-1:0] marker_cnt_o,
  output logic [stat_width_p-1:0] lost_cnt_o
);

  localparam int   word_w_lp    = sample_width_p + 1;
  localparam int   tag_bit_lp   = sample_width_p;
  localparam sat_t stat_max_lp  = (sat_t'(1) << stat_width_p) - sat_t'(1);

  logic                    push, pop;
  logic [cnt_w_lp-1:0]     count, count_next;
  logic [word_w_lp-1:0]    head;
  logic [word_w_lp-1:0]    last_q, last_d;
  logic [cnt_w_lp-1:0]     hwm_q, hwm_d, hwm_base;
  logic [stat_width_p-1:0] marker_cnt_q, marker_cnt_d, marker_base;
  logic [stat_width_p-1:0] lost_cnt_q, lost_cnt_d, lost_base;
  logic                    is_marker;
  logic [counter_width_p-1:0] drop_field;
  sat_t                    lost_inc;

  trace_fifo_mem #(
    .width_p (word_w_lp),
    .els_p   (els_p)
  ) u_mem (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (bus.fifo_data_i),
    .rdata_o      (head),
    .count_o      (count),
    .count_next_o (count_next)
  );

  // Ready comes from registered occupancy only: no pass-through when full.
  assign bus.fifo_ready_o = (count < cnt_w_lp'(els_p));
  assign bus.v_o          = (count != '0);
  assign push             = bus.fifo_valid_i & bus.fifo_ready_o;
  assign pop              = bus.v_o & bus.ready_i;
  assign bus.data_o       = bus.v_o ? head : last_q;

  always_comb begin
    is_marker   = bus.fifo_data_i[tag_bit_lp];
    drop_field  = bus.fifo_data_i[counter_width_p-1:0];
    // A drop field of P reports P-1 lost samples.
    lost_inc    = (drop_field > counter_width_p'(1)) ? sat_t'(drop_field) - sat_t'(1) : '0;

    hwm_base    = clear_stats_i ? '0 : hwm_q;
    marker_base = clear_stats_i ? '0 : marker_cnt_q;
    lost_base   = clear_stats_i ? '0 : lost_cnt_q;

    hwm_d        = (count_next > hwm_base) ? count_next : hwm_base;
    marker_cnt_d = marker_base;
    lost_cnt_d   = lost_base;
    if (push && is_marker) begin
      marker_cnt_d = stat_width_p'(sat_add(sat_t'(marker_base), sat_t'(1), stat_max_lp));
      lost_cnt_d   = stat_width_p'(sat_add(sat_t'(lost_base), lost_inc, stat_max_lp));
    end

    last_d = pop ? head : last_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q       <= '0;
      hwm_q        <= '0;
      marker_cnt_q <= '0;
      lost_cnt_q   <= '0;
    end else begin
      last_q       <= last_d;
      hwm_q        <= hwm_d;
      marker_cnt_q <= marker_cnt_d;
      lost_cnt_q   <= lost_cnt_d;
    end
  end

  assign count_o      = count;
  assign hwm_o        = hwm_q;
  assign marker_cnt_o = marker_cnt_q;
  assign lost_cnt_o   = lost_cnt_q;

endmodule
